delay_line_prog: RTL and testbench
==================================

# delay_line_prog

Runtime-programmable, stallable delay line for `WIDTH`-bit data with a per-sample valid flag. The delay is selected by an input port between 0 and `MAX_DEL` clock-enabled cycles. The block is the general-purpose replacement for fixed-depth pixel/timing alignment delays in the video pipeline. It adds a clock enable, synchronous flush, live delay changes with valid suppression, and out-of-range clamping.

## Interface
- `WIDTH`, 12: data bit width.
- `MAX_DEL`, 8: maximum delay in cycles; number of physical stages; ≥1.
- `DEL_W`, 4: width of `del_sel`; requires 2^`DEL_W` > `MAX_DEL`.
- `DEF_DEL`, 2: delay active after reset; 0..`MAX_DEL`.
- `clk` in 1: posedge clock.
- `rst` in 1: reset, asynchronous, active-high.
- `ce` in 1: clock enable; low = full stall.
- `flush` in 1: synchronous clear of all stages.
- `del_sel` in `DEL_W`: requested delay in ce-cycles.
- `din_valid` in 1: `din` qualifier.
- `din` in `WIDTH`: input data.
- `dout` out `WIDTH`: delayed data.
- `dout_valid` out 1: delayed qualifier.
- `del_chg` out 1: one-cycle pulse; a new delay was applied.
- `sel_err` out 1: high while `del_sel` > `MAX_DEL`.

## Operation
- Storage: `MAX_DEL` stages, each holding data and a valid bit. Register `del_q` (`DEL_W` bits) holds the active delay.
- Effective request: `eff = min(del_sel, MAX_DEL)`. `sel_err = (del_sel > MAX_DEL)`, combinational.
- Shift: when `ce`=1 and `flush`=0:
  - stage0 ← {`din_valid`, `din`};
  - stage i ← stage i-1.
- Stall: when `ce`=0 and `flush`=0, all stages and `del_q` hold.
- Output mux:
  - `del_q`=0: `dout`=`din` and `dout_valid`=`din_valid`, combinational pass-through.
  - `del_q`=k>0: outputs = stage k-1.
- Delay change: when `ce`=1 and `eff` ≠ `del_q`:
  - `del_q` ← `eff`;
  - every stage valid bit clears on that edge (data is shifted normally, valid bits are forced 0);
  - `del_chg`=1 for the following cycle.
- Stale samples are never re-emitted: after a change, `dout_valid` stays low until the first sample entered after the change reaches stage `eff`-1.
- Delay changes are evaluated only when `ce`=1; `del_sel` is ignored while stalled.
- Flush: on a `flush`=1 edge, every stage's data ← 0 and valid ← 0, regardless of `ce`.
  - `din` on that edge is discarded.
  - `del_q` still updates per the change rule if `ce`=1. `del_chg` then pulses, and valid is cleared either way.
- Priority per edge: `rst` > `flush` > delay change > shift/stall.
- `MAX_DEL`=`DEF_DEL`=`del_sel`=2 with `ce`=1, `flush`=0 gives behaviour identical to a fixed 2-cycle delay.

## Timing
- Reset values: all stage data 0, stage valid 0, `del_q`=`DEF_DEL`, `del_chg`=0.
  - `dout`=0 and `dout_valid`=0, unless `DEF_DEL`=0, in which case outputs follow `din`/`din_valid`.
  - `sel_err` tracks `del_sel` even during reset.
- Latency: a sample presented on ce-edge n appears on `dout` after edge n+`del_q`-1, i.e. in the cycle following `del_q` ce-edges. Stalled cycles do not count.
- Throughput: one sample per ce-cycle, no bubbles.
- Refill after a change to delay k>0: the first valid output appears exactly k ce-edges after the change edge.
- Reset asserted mid-stream: outputs take reset values asynchronously. The first valid output comes `DEF_DEL` ce-edges after deassertion.
- `del_chg` is registered. It is high exactly one clock after the change edge, independent of later `ce`.

## Test plan
- Reset, `DEF_DEL`=2, `ce`=1, ramp `din`=1,2,3… valid → `dout` = 1 two edges after it was applied; `dout_valid` rises on the same cycle; no gaps.
- `del_sel` 2→5 mid-ramp → `del_chg` pulses once; `dout_valid` low for 5 edges; first valid `dout` equals the `din` sampled on the change edge + 1; no value repeats.
- `ce` toggled 1,0,0,1 during the ramp → `dout` frozen while `ce`=0; latency counted in ce-edges only.
- `flush` pulse with `ce`=0 → all valid cleared; `dout`=0; `dout_valid`=0 until refill after `del_q` ce-edges.
- `del_sel`=12 with `MAX_DEL`=8 → `sel_err`=1; delay behaves as 8; `del_sel`=0 → `dout` equals `din` in the same cycle.
- `rst` pulsed mid-stream with `ce`=0 → outputs 0 immediately; `del_q` returns to 2.

Source files
------------

// File: rtl/delay_line_prog.sv
// rtl/delay_line_prog.sv - runtime-programmable, stallable delay line with valid flag
// Changing the delay invalidates in-flight samples so stale data is never re-emitted.
module delay_line_prog #(
  parameter int WIDTH   = 12,
  parameter int MAX_DEL = 8,
  parameter int DEL_W   = 4,
  parameter int DEF_DEL = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic             flush,
  input  logic [DEL_W-1:0] del_sel,
  input  logic             din_valid,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic             del_chg,
  output logic             sel_err
);

  localparam logic [DEL_W-1:0] MAX_DEL_W = DEL_W'(MAX_DEL);
  localparam logic [DEL_W-1:0] DEF_DEL_W = DEL_W'(DEF_DEL);

  logic [WIDTH-1:0] stage_data  [MAX_DEL];
  logic             stage_valid [MAX_DEL];
  logic [DEL_W-1:0] del_q;
  logic [DEL_W-1:0] eff;
  logic             change;

  assign sel_err = (del_sel > MAX_DEL_W);
  assign eff     = sel_err ? MAX_DEL_W : del_sel;
  assign change  = ce && (eff != del_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      del_q   <= DEF_DEL_W;
      del_chg <= 1'b0;
      for (int i = 0; i < MAX_DEL; i++) begin
        stage_data[i]  <= '0;
        stage_valid[i] <= 1'b0;
      end
    end else begin
      del_chg <= change;
      if (change)
        del_q <= eff;
      if (flush) begin
        for (int i = 0; i < MAX_DEL; i++) begin
          stage_data[i]  <= '0;
          stage_valid[i] <= 1'b0;
        end
      end else if (ce) begin
        // Data keeps moving on a delay change; only the valid bits are dropped.
        stage_data[0]  <= din;
        stage_valid[0] <= din_valid && !change;
        for (int i = 1; i < MAX_DEL; i++) begin
          stage_data[i]  <= stage_data[i-1];
          stage_valid[i] <= stage_valid[i-1] && !change;
        end
      end
    end
  end

  always_comb begin
    dout       = din;
    dout_valid = din_valid;
    for (int i = 0; i < MAX_DEL; i++) begin
      if (del_q == DEL_W'(i + 1)) begin
        dout       = stage_data[i];
        dout_valid = stage_valid[i];
      end
    end
  end

endmodule

// File: tb/tb_delay_line_prog.sv
// tb/tb_delay_line_prog.sv - directed self-checking bench for delay_line_prog
module tb_delay_line_prog;

  logic        clk = 1'b0;
  logic        rst;
  logic        ce;
  logic        flush;
  logic [3:0]  del_sel;
  logic        din_valid;
  logic [11:0] din;
  logic [11:0] dout;
  logic        dout_valid;
  logic        del_chg;
  logic        sel_err;

  int checks = 0;
  int errors = 0;

  delay_line_prog #(.WIDTH(12), .MAX_DEL(8), .DEL_W(4), .DEF_DEL(2)) dut (
    .clk(clk), .rst(rst), .ce(ce), .flush(flush), .del_sel(del_sel),
    .din_valid(din_valid), .din(din), .dout(dout), .dout_valid(dout_valid),
    .del_chg(del_chg), .sel_err(sel_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; ce = 1'b1; flush = 1'b0; del_sel = 4'd12; din_valid = 1'b1; din = 12'd77;
    tick();
    checks++; if (sel_err !== 1'b1) begin errors++; $display("FAIL rst_sel_err got=%0b exp=1", sel_err); end
    del_sel = 4'd2;
    tick();
    checks++; if (sel_err !== 1'b0) begin errors++; $display("FAIL rst_sel_ok got=%0b exp=0", sel_err); end
    checks++; if (dout !== 12'd0 || dout_valid !== 1'b0) begin errors++; $display("FAIL rst_out got=%0d/%0b exp=0/0", dout, dout_valid); end
    checks++; if (del_chg !== 1'b0) begin errors++; $display("FAIL rst_chg got=%0b exp=0", del_chg); end
    din_valid = 1'b0; din = 12'd0;
    rst = 1'b0;
  endtask

  task automatic test_ramp();
    for (int i = 1; i <= 8; i++) begin
      din = 12'(i); din_valid = 1'b1;
      tick();
      checks++;
      if (i == 1) begin
        if (dout_valid !== 1'b0) begin errors++; $display("FAIL ramp_first got_v=%0b exp=0", dout_valid); end
      end else if (dout !== 12'(i - 1) || dout_valid !== 1'b1) begin
        errors++; $display("FAIL ramp i=%0d got=%0d/%0b exp=%0d/1", i, dout, dout_valid, i - 1);
      end
    end
  endtask

  task automatic test_delay_change();
    din = 12'd9; del_sel = 4'd5;
    tick();
    checks++; if (del_chg !== 1'b1 || dout_valid !== 1'b0) begin errors++; $display("FAIL chg_edge chg=%0b v=%0b exp=1/0", del_chg, dout_valid); end
    for (int j = 1; j <= 7; j++) begin
      din = 12'(9 + j);
      tick();
      checks++; if (del_chg !== 1'b0) begin errors++; $display("FAIL chg_pulse j=%0d got=%0b exp=0", j, del_chg); end
      checks++;
      if (j < 5) begin
        if (dout_valid !== 1'b0) begin errors++; $display("FAIL chg_refill j=%0d got_v=%0b exp=0", j, dout_valid); end
      end else if (dout !== 12'(5 + j) || dout_valid !== 1'b1) begin
        errors++; $display("FAIL chg_data j=%0d got=%0d/%0b exp=%0d/1", j, dout, dout_valid, 5 + j);
      end
    end
  endtask

  task automatic test_ce_stall();
    ce = 1'b0; din = 12'd100; del_sel = 4'd3;
    for (int j = 0; j < 2; j++) begin
      tick();
      checks++; if (dout !== 12'd12 || dout_valid !== 1'b1 || del_chg !== 1'b0) begin
        errors++; $display("FAIL stall j=%0d got=%0d/%0b chg=%0b exp=12/1/0", j, dout, dout_valid, del_chg);
      end
    end
    del_sel = 4'd5; ce = 1'b1;
    for (int j = 0; j < 2; j++) begin
      din = 12'(17 + j);
      tick();
      checks++; if (dout !== 12'(13 + j) || dout_valid !== 1'b1) begin
        errors++; $display("FAIL stall_resume j=%0d got=%0d/%0b exp=%0d/1", j, dout, dout_valid, 13 + j);
      end
    end
  endtask

  task automatic test_flush();
    ce = 1'b0; flush = 1'b1; din = 12'd200;
    tick();
    checks++; if (dout !== 12'd0 || dout_valid !== 1'b0) begin errors++; $display("FAIL flush got=%0d/%0b exp=0/0", dout, dout_valid); end
    flush = 1'b0;
    tick();
    checks++; if (dout !== 12'd0 || dout_valid !== 1'b0) begin errors++; $display("FAIL flush_hold got=%0d/%0b exp=0/0", dout, dout_valid); end
    ce = 1'b1;
    for (int j = 1; j <= 6; j++) begin
      din = 12'(18 + j);
      tick();
      checks++;
      if (j < 5) begin
        if (dout_valid !== 1'b0 || del_chg !== 1'b0) begin errors++; $display("FAIL flush_refill j=%0d got_v=%0b chg=%0b exp=0/0", j, dout_valid, del_chg); end
      end else if (dout !== 12'(14 + j) || dout_valid !== 1'b1) begin
        errors++; $display("FAIL flush_data j=%0d got=%0d/%0b exp=%0d/1", j, dout, dout_valid, 14 + j);
      end
    end
  endtask

  task automatic test_clamp();
    del_sel = 4'd12; din = 12'd25;
    #1;
    checks++; if (sel_err !== 1'b1) begin errors++; $display("FAIL clamp_err got=%0b exp=1", sel_err); end
    tick();
    checks++; if (del_chg !== 1'b1 || dout_valid !== 1'b0) begin errors++; $display("FAIL clamp_edge chg=%0b v=%0b exp=1/0", del_chg, dout_valid); end
    for (int j = 1; j <= 9; j++) begin
      din = 12'(25 + j);
      tick();
      checks++;
      if (j < 8) begin
        if (dout_valid !== 1'b0 || del_chg !== 1'b0) begin errors++; $display("FAIL clamp_refill j=%0d got_v=%0b chg=%0b exp=0/0", j, dout_valid, del_chg); end
      end else if (dout !== 12'(18 + j) || dout_valid !== 1'b1) begin
        errors++; $display("FAIL clamp_data j=%0d got=%0d/%0b exp=%0d/1", j, dout, dout_valid, 18 + j);
      end
    end
  endtask

  task automatic test_zero();
    del_sel = 4'd0; din = 12'd35;
    tick();
    checks++; if (del_chg !== 1'b1 || sel_err !== 1'b0) begin errors++; $display("FAIL zero_edge chg=%0b err=%0b exp=1/0", del_chg, sel_err); end
    checks++; if (dout !== 12'd35 || dout_valid !== 1'b1) begin errors++; $display("FAIL zero_pass got=%0d/%0b exp=35/1", dout, dout_valid); end
    din = 12'd36;
    #1;
    checks++; if (dout !== 12'd36 || dout_valid !== 1'b1) begin errors++; $display("FAIL zero_comb got=%0d/%0b exp=36/1", dout, dout_valid); end
    din_valid = 1'b0;
    #1;
    checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL zero_valid got=%0b exp=0", dout_valid); end
    din_valid = 1'b1;
  endtask

  task automatic test_rst_mid();
    del_sel = 4'd2; din = 12'd39;
    tick();
    din = 12'd40;
    tick();
    din = 12'd41;
    tick();
    checks++; if (dout !== 12'd40 || dout_valid !== 1'b1) begin errors++; $display("FAIL mid_pre got=%0d/%0b exp=40/1", dout, dout_valid); end
    ce = 1'b0;
    #3 rst = 1'b1;
    #1;
    checks++; if (dout !== 12'd0 || dout_valid !== 1'b0) begin errors++; $display("FAIL mid_rst got=%0d/%0b exp=0/0", dout, dout_valid); end
    rst = 1'b0; ce = 1'b1; din = 12'd50;
    tick();
    checks++; if (dout_valid !== 1'b0 || del_chg !== 1'b0) begin errors++; $display("FAIL mid_first got_v=%0b chg=%0b exp=0/0", dout_valid, del_chg); end
    din = 12'd51;
    tick();
    checks++; if (dout !== 12'd50 || dout_valid !== 1'b1 || del_chg !== 1'b0) begin
      errors++; $display("FAIL mid_refill got=%0d/%0b chg=%0b exp=50/1/0", dout, dout_valid, del_chg);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_ramp();
    test_delay_change();
    test_ce_stall();
    test_flush();
    test_clamp();
    test_zero();
    test_rst_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
